// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: execute-stage sequencer for an iterative 32-bit radix-2 divider.
// It latches the DIV/DIVU operands and drives start/annul/signed to the divider.
// It stalls the pipeline until the result is ready, then commits the result to HI/LO.
// It owns HI/LO, including MTHI/MTLO writes. A flush annuls an in-flight divide.
// Optional build macro: DIV_ZERO_BYPASS_EN. When defined, a zero divisor skips
// the divider entirely and leaves HI/LO unchanged.
module div_issue_ctrl #(
  parameter logic [31:0] HI_RST       = 32'h0000_0000,
  parameter logic [31:0] LO_RST       = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_div_valid_i,
  input  logic        ex_div_signed_i,
  input  logic [31:0] ex_op1_i,
  input  logic [31:0] ex_op2_i,
  input  logic        flush_i,
  input  logic        mthi_we_i,
  input  logic        mtlo_we_i,
  input  logic [31:0] mt_data_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stall_req_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned     CNT_W      = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             start_q, start_d;
  logic             annul_q, annul_d;
  logic             signed_q, signed_d;
  logic [31:0]      op1_q, op1_d;
  logic [31:0]      op2_q, op2_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [CNT_W-1:0] drain_q, drain_d;
  logic             bypass;

`ifdef DIV_ZERO_BYPASS_EN
  assign bypass = (ex_op2_i == '0);
`else
  assign bypass = 1'b0;
`endif

  // Next-state, operand latch and HI/LO update logic.
  // MT writes are applied first so that a divide capture in the same cycle overrides them.
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    annul_d  = 1'b0;
    signed_d = signed_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    drain_d  = drain_q;

    if (mthi_we_i) hi_d = mt_data_i;
    if (mtlo_we_i) lo_d = mt_data_i;

    unique case (state_q)
      S_IDLE: begin
        if (ex_div_valid_i && !flush_i) begin
          if (bypass) begin
            state_d = S_DONE;
          end else begin
            op1_d    = ex_op1_i;
            op2_d    = ex_op2_i;
            signed_d = ex_div_signed_i;
            start_d  = 1'b1;
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (flush_i) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          drain_d = '0;
          state_d = S_DRAIN;
        end else if (div_ready_i) begin
          hi_d    = div_result_i[63:32];
          lo_d    = div_result_i[31:0];
          start_d = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        start_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      annul_q  <= 1'b0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      hi_q     <= HI_RST;
      lo_q     <= LO_RST;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      annul_q  <= annul_d;
      signed_q <= signed_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      drain_q  <= drain_d;
    end
  end

  assign div_start_o   = start_q;
  assign div_annul_o   = annul_q;
  assign div_signed_o  = signed_q;
  assign div_opdata1_o = op1_q;
  assign div_opdata2_o = op2_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign busy_o        = (state_q != S_IDLE);
  assign stall_req_o   = ex_div_valid_i && !flush_i &&
                         ((state_q == S_IDLE) || (state_q == S_RUN));

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed self-checking bench for div_issue_ctrl with a behavioural divider model.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_div_valid_i, ex_div_signed_i;
  logic [31:0] ex_op1_i, ex_op2_i;
  logic        flush_i, mthi_we_i, mtlo_we_i;
  logic [31:0] mt_data_i;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_opdata1_o, div_opdata2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stall_req_o, busy_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.HI_RST(32'h0), .LO_RST(32'h0), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .resetn(resetn),
    .ex_div_valid_i(ex_div_valid_i), .ex_div_signed_i(ex_div_signed_i),
    .ex_op1_i(ex_op1_i), .ex_op2_i(ex_op2_i), .flush_i(flush_i),
    .mthi_we_i(mthi_we_i), .mtlo_we_i(mtlo_we_i), .mt_data_i(mt_data_i),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .stall_req_o(stall_req_o), .busy_o(busy_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  // Divider model: ready in start cycle 35 (nonzero divisor) or 3 (zero divisor).
  int dcnt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) dcnt <= 0;
    else if (!div_start_o || div_annul_o) dcnt <= 0;
    else dcnt <= dcnt + 1;
  end
  assign div_ready_i = div_start_o && !div_annul_o &&
                       (dcnt == ((div_opdata2_o == 32'd0) ? 2 : 34));

  logic signed [31:0] a_s, b_s;
  always_comb begin
    a_s = div_opdata1_o;
    b_s = div_opdata2_o;
    div_result_i = '0;
    if (div_opdata2_o != 32'd0) begin
      if (div_signed_o) div_result_i = {a_s % b_s, a_s / b_s};
      else div_result_i = {div_opdata1_o % div_opdata2_o, div_opdata1_o / div_opdata2_o};
    end
  end

  // Issues one divide, holds valid while stalled, returns in the DONE cycle.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic mt_cap, output int stall_n, output int start_n,
                         output int op_bad);
    bit done = 0;
    stall_n = 0; start_n = 0; op_bad = 0;
    @(negedge clk);
    ex_div_valid_i = 1; ex_div_signed_i = sgn; ex_op1_i = a; ex_op2_i = b;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (div_start_o) begin
        start_n++;
        if (div_opdata1_o !== a || div_opdata2_o !== b || div_signed_o !== sgn) op_bad++;
      end
      if (!stall_req_o) done = 1;
      else begin
        stall_n++;
        if (mt_cap && div_ready_i) begin mtlo_we_i = 1; mt_data_i = 32'hAAAA5555; end
        @(negedge clk);
        mtlo_we_i = 0;
      end
    end
    ex_div_valid_i = 0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL run_div_timeout: stall still %0b after 100 cycles, required 0", stall_req_o);
    end
  endtask

  task automatic test_reset;
    resetn = 0;
    #1;
    checks++;
    if ({div_start_o, div_annul_o, div_signed_o, busy_o} !== 4'b0 ||
        hi_o !== 32'h0 || lo_o !== 32'h0 || div_opdata1_o !== 32'h0 || div_opdata2_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: start=%0b annul=%0b sgn=%0b busy=%0b hi=%h lo=%h required all 0",
               div_start_o, div_annul_o, div_signed_o, busy_o, hi_o, lo_o);
    end
    @(negedge clk); resetn = 1;
  endtask

  task automatic test_mt;
    @(negedge clk); mthi_we_i = 1; mt_data_i = 32'hDEADBEEF;
    @(negedge clk); mthi_we_i = 0; mtlo_we_i = 1; mt_data_i = 32'h12345678;
    #1; checks++;
    if (hi_o !== 32'hDEADBEEF) begin errors++; $display("FAIL mthi: hi=%h required deadbeef", hi_o); end
    @(negedge clk); mtlo_we_i = 0;
    #1; checks++;
    if (lo_o !== 32'h12345678) begin errors++; $display("FAIL mtlo: lo=%h required 12345678", lo_o); end
    checks++;
    if (hi_o !== 32'hDEADBEEF) begin errors++; $display("FAIL mtlo_keeps_hi: hi=%h required deadbeef", hi_o); end
  endtask

  task automatic test_divu;
    int s, st, bad;
    run_div(0, 32'd100, 32'd7, 0, s, st, bad);
    checks++;
    if (s !== 36) begin errors++; $display("FAIL divu_stall: %0d cycles, required 36", s); end
    checks++;
    if (st !== 35) begin errors++; $display("FAIL divu_start: %0d cycles, required 35", st); end
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL divu_done_busy: busy=%0b required 1", busy_o); end
    @(negedge clk); #1;
    checks++;
    if (hi_o !== 32'd2 || lo_o !== 32'd14) begin
      errors++; $display("FAIL divu_result: hi=%h lo=%h required 2 e", hi_o, lo_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL divu_idle_busy: busy=%0b required 0", busy_o); end
  endtask

  task automatic test_div_signed;
    int s, st, bad;
    run_div(1, 32'hFFFFFFF9, 32'd2, 0, s, st, bad);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL div_operand_hold: %0d unstable cycles, required 0", bad); end
    checks++;
    if (s !== 36) begin errors++; $display("FAIL div_stall: %0d cycles, required 36", s); end
    @(negedge clk); #1;
    checks++;
    if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_signed_result: hi=%h lo=%h required ffffffff fffffffd", hi_o, lo_o);
    end
  endtask

  task automatic test_mt_on_capture;
    int s, st, bad;
    run_div(0, 32'd100, 32'd7, 1, s, st, bad);
    @(negedge clk); #1;
    checks++;
    if (hi_o !== 32'd2 || lo_o !== 32'd14) begin
      errors++; $display("FAIL capture_beats_mtlo: hi=%h lo=%h required 2 e", hi_o, lo_o);
    end
  endtask

  task automatic test_flush;
    int s, st, bad;
    @(negedge clk);
    ex_div_valid_i = 1; ex_div_signed_i = 1; ex_op1_i = 32'd20; ex_op2_i = 32'd3;
    for (int c = 0; c < 10; c++) @(negedge clk);
    flush_i = 1; #1;
    checks++;
    if (stall_req_o !== 1'b0 || div_start_o !== 1'b1) begin
      errors++; $display("FAIL flush_stall: stall=%0b start=%0b required 0 1", stall_req_o, div_start_o);
    end
    @(negedge clk); flush_i = 0; ex_div_valid_i = 0; #1;
    checks++;
    if (div_annul_o !== 1'b1 || div_start_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL drain1: annul=%0b start=%0b busy=%0b required 1 0 1",
                         div_annul_o, div_start_o, busy_o);
    end
    @(negedge clk); #1;
    checks++;
    if (div_annul_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL drain2: annul=%0b busy=%0b required 0 1", div_annul_o, busy_o);
    end
    @(negedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || hi_o !== 32'd2 || lo_o !== 32'd14) begin
      errors++; $display("FAIL flush_no_write: busy=%0b hi=%h lo=%h required 0 2 e", busy_o, hi_o, lo_o);
    end
    run_div(0, 32'd9, 32'd3, 0, s, st, bad);
    @(negedge clk); #1;
    checks++;
    if (hi_o !== 32'd0 || lo_o !== 32'd3) begin
      errors++; $display("FAIL after_flush_result: hi=%h lo=%h required 0 3", hi_o, lo_o);
    end
  endtask

  task automatic test_div_zero;
    int s, st, bad;
    @(negedge clk); mthi_we_i = 1; mtlo_we_i = 1; mt_data_i = 32'h11112222;
    @(negedge clk); mthi_we_i = 0; mtlo_we_i = 0; #1;
    checks++;
    if (hi_o !== 32'h11112222 || lo_o !== 32'h11112222) begin
      errors++; $display("FAIL mt_both: hi=%h lo=%h required 11112222 11112222", hi_o, lo_o);
    end
    run_div(0, 32'd55, 32'd0, 0, s, st, bad);
    @(negedge clk); #1;
`ifdef DIV_ZERO_BYPASS_EN
    checks++;
    if (s !== 1 || st !== 0) begin
      errors++; $display("FAIL zero_bypass_timing: stall=%0d start=%0d required 1 0", s, st);
    end
    checks++;
    if (hi_o !== 32'h11112222 || lo_o !== 32'h11112222) begin
      errors++; $display("FAIL zero_bypass_hilo: hi=%h lo=%h required unchanged", hi_o, lo_o);
    end
`else
    checks++;
    if (s !== 4 || st !== 3) begin
      errors++; $display("FAIL zero_timing: stall=%0d start=%0d required 4 3", s, st);
    end
    checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      errors++; $display("FAIL zero_hilo: hi=%h lo=%h required 0 0", hi_o, lo_o);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int s1, s2, st, bad;
    run_div(0, 32'd100, 32'd7, 0, s1, st, bad);
    run_div(0, 32'd9, 32'd3, 0, s2, st, bad);
    checks++;
    if (s1 !== 36 || s2 !== 36) begin
      errors++; $display("FAIL b2b_stall: %0d %0d cycles, required 36 36", s1, s2);
    end
    @(negedge clk); #1;
    checks++;
    if (hi_o !== 32'd0 || lo_o !== 32'd3) begin
      errors++; $display("FAIL b2b_result: hi=%h lo=%h required 0 3", hi_o, lo_o);
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk); mthi_we_i = 1; mtlo_we_i = 1; mt_data_i = 32'h5A5A5A5A;
    @(negedge clk); mthi_we_i = 0; mtlo_we_i = 0;
    ex_div_valid_i = 1; ex_div_signed_i = 1; ex_op1_i = 32'd77; ex_op2_i = 32'd5;
    for (int c = 0; c < 6; c++) @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b1 || div_start_o !== 1'b1) begin
      errors++; $display("FAIL pre_reset_run: busy=%0b start=%0b required 1 1", busy_o, div_start_o);
    end
    resetn = 0; #1;
    checks++;
    if ({div_start_o, div_annul_o, div_signed_o, busy_o} !== 4'b0 ||
        hi_o !== 32'h0 || lo_o !== 32'h0 || div_opdata1_o !== 32'h0 || div_opdata2_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_run: start=%0b annul=%0b sgn=%0b busy=%0b hi=%h lo=%h op1=%h required all 0",
               div_start_o, div_annul_o, div_signed_o, busy_o, hi_o, lo_o, div_opdata1_o);
    end
    ex_div_valid_i = 0;
    @(negedge clk); resetn = 1;
    @(negedge clk);
  endtask

  initial begin
    ex_div_valid_i = 0; ex_div_signed_i = 0; ex_op1_i = '0; ex_op2_i = '0;
    flush_i = 0; mthi_we_i = 0; mtlo_we_i = 0; mt_data_i = '0;
    test_reset;
    test_mt;
    test_divu;
    test_div_signed;
    test_mt_on_capture;
    test_flush;
    test_div_zero;
    test_back_to_back;
    test_reset_mid_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
